tb_test_sequencer: RTL and testbench
====================================

Name: tb_test_sequencer

Overview:
- Synthesizable-style scheduler for test-bench modules sharing one clock from the bench clock generator.
- After reset, waits a settle period, then launches NUM_TESTS test-bench modules one at a time.
- Each launch is a one-cycle start pulse; the sequencer then waits for that test's done/pass handshake, guarded by a watchdog.
- Records per-test results and raises all_done when the schedule completes.

Parameters:
- NUM_TESTS, 4, number of scheduled test-bench modules (1..16).
- SETTLE_CYCLES, 4, cycles to wait after reset before the first launch (>=1).
- TIMEOUT_CYCLES, 64, watchdog limit per test in WAIT cycles (>=1).

Ports:
- clk  input  1  bench clock, rising edge only.
- reset  input  1  synchronous, active-low reset (0 = in reset).
- test_done  input  NUM_TESTS  per-test completion; only bit cur_test is honoured.
- test_pass  input  NUM_TESTS  per-test verdict; sampled together with test_done.
- test_start  output  NUM_TESTS  one-hot, one-cycle launch pulse.
- cur_test  output  $clog2(NUM_TESTS) (min 1)  index of the active test.
- pass_vec  output  NUM_TESTS  bit i set = test i passed.
- fail_vec  output  NUM_TESTS  bit i set = test i failed or timed out.
- timeout_vec  output  NUM_TESTS  bit i set = test i hit the watchdog.
- pass_count  output  $clog2(NUM_TESTS+1)  number of passes.
- fail_count  output  $clog2(NUM_TESTS+1)  number of failures, including timeouts.
- all_done  output  1  schedule finished; held until reset.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=SETTLE; settle_cnt=0; wd_cnt=0; cur_test=0.
  - All result vectors and counts 0; test_start=0; all_done=0.
  - Reset mid-run aborts immediately; the test_start pulse is dropped the same cycle.
- SETTLE:
  - settle_cnt increments each edge.
  - When settle_cnt==SETTLE_CYCLES-1: go to LAUNCH.
  - The first test_start is therefore high in the cycle after SETTLE_CYCLES post-reset edges.
- LAUNCH:
  - test_start[cur_test]=1 for exactly this one cycle, decoded from registered state; all other bits 0.
  - wd_cnt cleared; next state WAIT.
  - test_done is ignored in this cycle.
- WAIT (wd_cnt increments each edge):
  - test_done[cur_test]==1: set pass_vec[cur_test] if test_pass[cur_test]==1, else set fail_vec[cur_test]; then advance.
  - Otherwise, if wd_cnt==TIMEOUT_CYCLES-1: set fail_vec[cur_test] and timeout_vec[cur_test]; then advance.
  - If done and timeout coincide in the same cycle, done wins and no timeout is recorded.
  - test_done/test_pass bits for indices other than cur_test are ignored in every state.
- Advance:
  - If cur_test==NUM_TESTS-1: go to DONE.
  - Else cur_test++ and go to LAUNCH.
  - Back-to-back tests: the next LAUNCH occurs on the edge right after the completing WAIT cycle.
- DONE:
  - all_done=1.
  - cur_test holds its final value.
  - Inputs ignored; state held until reset.
- Counts:
  - pass_count/fail_count update on the same edge as their vector bit.
  - Invariant in DONE: pass_count + fail_count == NUM_TESTS.
- Widths: counters sized with $clog2 of their limit; no wrap-around is possible, since each counter is cleared at its terminal value.

Optional Feature:
- TB_SEQ_STOP_ON_FAIL_EN.
- Defined: the first failure or timeout sends the FSM directly to DONE. Remaining tests stay unlaunched; their pass_vec/fail_vec bits stay 0. all_done=1 still asserts.
- Undefined: all tests run regardless of results.

Decomposition:
- Package tb_seq_pkg holds:
  - the state enum: SETTLE, LAUNCH, WAIT, DONE (2-bit logic);
  - a width helper constant function for index/count widths.
- One sub-module: tb_watchdog_counter.
  - Parameter LIMIT; inputs clk, reset, clear, enable; output expired (high when count==LIMIT-1 and enable).
  - Instantiated once for wd_cnt. settle_cnt reuses a second instance with LIMIT=SETTLE_CYCLES.

Test Plan (NUM_TESTS=3, SETTLE_CYCLES=4, TIMEOUT_CYCLES=8 unless noted):
- Release reset, all tests assert done+pass 2 cycles after start -> start pulses test_start=001, 010, 100, one cycle each, first after 4 edges; pass_vec=111, pass_count=3, all_done=1.
- Test 1 returns done with pass=0 -> fail_vec=010, pass_count=2, fail_count=1, timeout_vec=000.
- Test 2 never asserts done -> after 8 WAIT cycles fail_vec=100, timeout_vec=100; all_done=1 on the next edge.
- test_done[cur_test] rises exactly when wd_cnt==7, and test_done[2] is asserted while test 0 runs -> pass recorded, no timeout; the stray bit is ignored.
- reset pulled low for one edge during test 1's WAIT -> all outputs return to 0, cur_test=0; the schedule restarts from SETTLE.
- With TB_SEQ_STOP_ON_FAIL_EN, test 0 fails -> all_done=1 directly after test 0's WAIT; test_start never shows 010; fail_vec=001, pass_vec=000.

Source files
------------

// File: rtl/tb_seq_pkg.sv
// Shared types and width helper for the test-bench sequencer.
package tb_seq_pkg;

    typedef enum logic [1:0] {
        StSettle = 2'd0,
        StLaunch = 2'd1,
        StWait   = 2'd2,
        StDone   = 2'd3
    } tb_seq_state_e;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned tb_seq_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tb_watchdog_counter.sv
// Free-running terminal counter: counts enabled cycles and clears itself at LIMIT-1.
module tb_watchdog_counter
    import tb_seq_pkg::*;
#(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntW = tb_seq_width(LIMIT);
    localparam logic [CntW-1:0] LastCnt = CntW'(LIMIT - 1);

    logic [CntW-1:0] r_cnt;

    assign expired = enable && (r_cnt == LastCnt);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clear || expired) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end

endmodule

// File: rtl/tb_test_sequencer.sv
// Launches NUM_TESTS bench modules in turn and records pass/fail/timeout per test.
// Define TB_SEQ_STOP_ON_FAIL_EN to end the schedule at the first failure or timeout.
module tb_test_sequencer
    import tb_seq_pkg::*;
#(
    parameter int unsigned NUM_TESTS      = 4,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [NUM_TESTS-1:0]                        test_done,
    input  logic [NUM_TESTS-1:0]                        test_pass,
    output logic [NUM_TESTS-1:0]                        test_start,
    output logic [tb_seq_width(NUM_TESTS)-1:0]          cur_test,
    output logic [NUM_TESTS-1:0]                        pass_vec,
    output logic [NUM_TESTS-1:0]                        fail_vec,
    output logic [NUM_TESTS-1:0]                        timeout_vec,
    output logic [tb_seq_width(NUM_TESTS + 1)-1:0]      pass_count,
    output logic [tb_seq_width(NUM_TESTS + 1)-1:0]      fail_count,
    output logic                                        all_done
);

    localparam int unsigned IdxW = tb_seq_width(NUM_TESTS);
    localparam int unsigned CntW = tb_seq_width(NUM_TESTS + 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_TESTS - 1);

    tb_seq_state_e         r_state;
    tb_seq_state_e         w_state_next;
    logic [IdxW-1:0]       r_cur;
    logic [NUM_TESTS-1:0]  r_pass;
    logic [NUM_TESTS-1:0]  r_fail;
    logic [NUM_TESTS-1:0]  r_timeout;
    logic [CntW-1:0]       r_pass_cnt;
    logic [CntW-1:0]       r_fail_cnt;

    logic w_in_settle;
    logic w_in_launch;
    logic w_in_wait;
    logic w_settle_done;
    logic w_wd_expired;
    logic w_done;
    logic w_pass;
    logic w_finish;
    logic w_pass_evt;
    logic w_fail_evt;
    logic w_stop;

    assign w_in_settle = (r_state == StSettle);
    assign w_in_launch = (r_state == StLaunch);
    assign w_in_wait   = (r_state == StWait);

    tb_watchdog_counter #(
        .LIMIT (SETTLE_CYCLES)
    ) u_settle_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (1'b0),
        .enable  (w_in_settle),
        .expired (w_settle_done)
    );

    tb_watchdog_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wd_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_in_launch),
        .enable  (w_in_wait),
        .expired (w_wd_expired)
    );

    // Only the active test's handshake is honoured; a done in the watchdog's last cycle wins.
    assign w_done     = test_done[r_cur];
    assign w_pass     = test_pass[r_cur];
    assign w_finish   = w_in_wait && (w_done || w_wd_expired);
    assign w_pass_evt = w_in_wait && w_done && w_pass;
    assign w_fail_evt = w_in_wait && (w_done ? !w_pass : w_wd_expired);

`ifdef TB_SEQ_STOP_ON_FAIL_EN
    assign w_stop = w_fail_evt;
`else
    assign w_stop = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StSettle: if (w_settle_done) w_state_next = StLaunch;
            StLaunch: w_state_next = StWait;
            StWait: begin
                if (w_finish) begin
                    w_state_next = ((r_cur == LastIdx) || w_stop) ? StDone : StLaunch;
                end
            end
            StDone:   w_state_next = StDone;
            default:  w_state_next = StSettle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= StSettle;
            r_cur      <= '0;
            r_pass     <= '0;
            r_fail     <= '0;
            r_timeout  <= '0;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_pass_evt) begin
                r_pass[r_cur] <= 1'b1;
                r_pass_cnt    <= r_pass_cnt + CntW'(1);
            end
            if (w_fail_evt) begin
                r_fail[r_cur] <= 1'b1;
                r_fail_cnt    <= r_fail_cnt + CntW'(1);
                if (!w_done) r_timeout[r_cur] <= 1'b1;
            end
            if (w_finish && (w_state_next == StLaunch)) r_cur <= r_cur + IdxW'(1);
        end
    end

    // Gated by reset so an abort drops the pulse in the very cycle reset is asserted.
    always_comb begin
        test_start = '0;
        if (w_in_launch && reset) test_start[r_cur] = 1'b1;
    end

    assign cur_test    = r_cur;
    assign pass_vec    = r_pass;
    assign fail_vec    = r_fail;
    assign timeout_vec = r_timeout;
    assign pass_count  = r_pass_cnt;
    assign fail_count  = r_fail_cnt;
    assign all_done    = (r_state == StDone);

endmodule

// File: tb/tb_tb_test_sequencer.sv
// Scoreboard bench for tb_test_sequencer: expected launches and results queued per schedule.
module tb_tb_test_sequencer;

    localparam int unsigned NT = 3;
    localparam int unsigned ST = 4;
    localparam int unsigned TO = 8;
`ifdef TB_SEQ_STOP_ON_FAIL_EN
    localparam bit StopOnFail = 1'b1;
`else
    localparam bit StopOnFail = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] test_done = 3'b000;
    logic [2:0] test_pass = 3'b000;
    logic [2:0] test_start;
    logic [1:0] cur_test;
    logic [2:0] pass_vec;
    logic [2:0] fail_vec;
    logic [2:0] timeout_vec;
    logic [1:0] pass_count;
    logic [1:0] fail_count;
    logic       all_done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int base = 0;
    logic [2:0] exp_start_q[$];
    int         exp_cyc_q[$];

    tb_test_sequencer #(
        .NUM_TESTS      (NT),
        .SETTLE_CYCLES  (ST),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .test_done   (test_done),
        .test_pass   (test_pass),
        .test_start  (test_start),
        .cur_test    (cur_test),
        .pass_vec    (pass_vec),
        .fail_vec    (fail_vec),
        .timeout_vec (timeout_vec),
        .pass_count  (pass_count),
        .fail_count  (fail_count),
        .all_done    (all_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, 32'({test_start, pass_vec, fail_vec, timeout_vec, pass_count, fail_count,
                        all_done, cur_test}), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        test_done = '0;
        test_pass = '0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_outputs");
        reset = 1'b1;
        base = cyc;
    endtask

    // d*: WAIT cycle in which test asserts done (>= TO means never); p*: its verdict.
    task automatic run_sched(input bit rst_first, input int d0, input int d1, input int d2,
                             input bit p0, input bit p1, input bit p2, input logic [2:0] stray,
                             input int abort_test, input int abort_wait, input string name);
        int dl[3];
        bit pl[3];
        logic [2:0] e_pass, e_fail, e_to;
        logic [1:0] e_np, e_nf, e_last;
        int lc, c, launched, j;
        bit stopped, finished;
        dl = '{d0, d1, d2};
        pl = '{p0, p1, p2};
        if (rst_first) do_reset();
        else base = cyc;

        exp_start_q.delete();
        exp_cyc_q.delete();
        e_pass = '0; e_fail = '0; e_to = '0; e_np = '0; e_nf = '0; e_last = '0;
        lc = base + ST;
        stopped = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!stopped) begin
                exp_start_q.push_back(3'b001 << k);
                exp_cyc_q.push_back(lc);
                e_last = 2'(k);
                c = (dl[k] < TO) ? dl[k] : TO - 1;
                if (dl[k] < TO && pl[k]) begin
                    e_pass[k] = 1'b1;
                    e_np++;
                end else begin
                    e_fail[k] = 1'b1;
                    e_nf++;
                    if (dl[k] >= TO) e_to[k] = 1'b1;
                    if (StopOnFail) stopped = 1'b1;
                end
                lc = lc + c + 2;
            end
        end

        launched = -1;
        j = 0;
        finished = 1'b0;
        for (int g = 0; g < 300; g++) begin
            @(negedge clk);
            if (all_done === 1'b1) begin
                finished = 1'b1;
                break;
            end
            if (test_start !== 3'b000) begin
                if (exp_start_q.size() == 0) begin
                    check({name, "_extra_start"}, 32'(test_start), 32'd0);
                end else begin
                    check({name, "_start"}, 32'(test_start), 32'(exp_start_q.pop_front()));
                    check({name, "_start_cyc"}, cyc, exp_cyc_q.pop_front());
                end
                launched++;
                j = -1;
                check({name, "_cur_test"}, 32'(cur_test), launched);
            end else begin
                j++;
            end
            if (launched == abort_test && j == abort_wait) begin
                reset = 1'b0;
                #1;
                check({name, "_abort_start_drop"}, 32'(test_start), 32'd0);
                @(posedge clk);
                @(negedge clk);
                check_all_zero({name, "_abort_outputs"});
                reset = 1'b1;
                test_done = '0;
                test_pass = '0;
                return;
            end
            test_done = '0;
            test_pass = '0;
            if (launched >= 0 && launched < 3 && j >= 0 && j == dl[launched]) begin
                test_done = 3'b001 << launched;
                if (pl[launched]) test_pass = 3'b001 << launched;
            end
            if (launched == 0) test_done = test_done | stray;
        end

        if (!finished) begin
            check({name, "_all_done_bound"}, 32'(all_done), 32'd1);
        end else begin
            check({name, "_done_cyc"}, cyc, lc);
            check({name, "_pass_vec"}, 32'(pass_vec), 32'(e_pass));
            check({name, "_fail_vec"}, 32'(fail_vec), 32'(e_fail));
            check({name, "_timeout_vec"}, 32'(timeout_vec), 32'(e_to));
            check({name, "_pass_count"}, 32'(pass_count), 32'(e_np));
            check({name, "_fail_count"}, 32'(fail_count), 32'(e_nf));
            check({name, "_unlaunched"}, exp_start_q.size(), 32'd0);
            test_done = 3'b111;
            test_pass = 3'b111;
            repeat (3) @(negedge clk);
            check({name, "_hold"},
                  32'({all_done, test_start, pass_vec, fail_vec, timeout_vec, cur_test}),
                  32'({1'b1, 3'b000, e_pass, e_fail, e_to, e_last}));
            test_done = '0;
            test_pass = '0;
        end
    endtask

    initial begin
        run_sched(1'b1, 1, 1, 1, 1'b1, 1'b1, 1'b1, 3'b000, -9, 0, "all_pass");
        run_sched(1'b1, 1, 0, 2, 1'b1, 1'b0, 1'b1, 3'b000, -9, 0, "fail1");
        run_sched(1'b1, 0, 2, 99, 1'b1, 1'b1, 1'b1, 3'b000, -9, 0, "timeout2");
        run_sched(1'b1, 7, 3, 3, 1'b1, 1'b1, 1'b1, 3'b100, -9, 0, "boundary");
        run_sched(1'b1, 1, 1, 1, 1'b1, 1'b1, 1'b1, 3'b000, 1, 1, "abort_wait");
        run_sched(1'b0, 1, 2, 0, 1'b1, 1'b1, 1'b1, 3'b000, -9, 0, "restart");
        run_sched(1'b1, 2, 2, 2, 1'b1, 1'b1, 1'b1, 3'b000, 1, -1, "abort_launch");
        run_sched(1'b0, 0, 4, 99, 1'b0, 1'b1, 1'b1, 3'b000, -9, 0, "fail0");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
